// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with an ASCII tempo-command decoder.
// Emits the received byte, valid/frame-error strobes and one-cycle command pulses.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CMD_ENABLE   = 1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_btn_plus_1,
  output logic       o_btn_plus_5,
  output logic       o_btn_minus_1,
  output logic       o_btn_minus_5,
  output logic       o_btn_reset
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             CMD_ON = (CMD_ENABLE != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift;
  logic             r_rx_meta, r_rx_s;
  logic             w_shift_en, w_done, w_err;
  logic             w_is_p1, w_is_p5, w_is_m1, w_is_m5, w_is_rst;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Counter starts at 1 in START so the cycle that detected the edge counts
  // toward the half-bit, keeping samples near bit centres under baud error.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == HALF) begin
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = S_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt  = '0;
          w_shift_en = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_is_p1  = (r_shift == 8'h2B) || (r_shift == 8'h75);
    w_is_p5  = (r_shift == 8'h55);
    w_is_m1  = (r_shift == 8'h2D) || (r_shift == 8'h64);
    w_is_m5  = (r_shift == 8'h44);
    w_is_rst = (r_shift == 8'h72) || (r_shift == 8'h52);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_shift       <= '0;
      o_rx_byte     <= '0;
      o_rx_valid    <= 1'b0;
      o_frame_err   <= 1'b0;
      o_btn_plus_1  <= 1'b0;
      o_btn_plus_5  <= 1'b0;
      o_btn_minus_1 <= 1'b0;
      o_btn_minus_5 <= 1'b0;
      o_btn_reset   <= 1'b0;
    end else begin
      if (w_shift_en) r_shift[r_idx] <= r_rx_s;
      if (w_done)     o_rx_byte      <= r_shift;
      o_rx_valid    <= w_done;
      o_frame_err   <= w_err;
      o_btn_plus_1  <= CMD_ON && w_done && w_is_p1;
      o_btn_plus_5  <= CMD_ON && w_done && w_is_p5;
      o_btn_minus_1 <= CMD_ON && w_done && w_is_m1;
      o_btn_minus_5 <= CMD_ON && w_done && w_is_m5;
      o_btn_reset   <= CMD_ON && w_done && w_is_rst;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomized self-checking bench for uart_cmd_rx: one decoder-enabled and one
// decoder-disabled instance, checked against a byte/command reference model.
module tb_uart_cmd_rx;
  localparam int CPB = 16;
  localparam int NOM = 10 * CPB;

  logic clk = 1'b0, rst_n = 1'b1, rx = 1'b1, rx0 = 1'b1;
  logic [7:0] byte1, byte0;
  logic valid1, err1, p1, p5, m1, m5, rs;
  logic valid0, err0, q1, q5, n1, n5, ns;
  wire  [4:0] cmd1 = {rs, m5, m1, p5, p1};
  wire  [4:0] cmd0 = {ns, n5, n1, q5, q1};

  always #5 clk = ~clk;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .CMD_ENABLE(1)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx),
    .o_rx_byte(byte1), .o_rx_valid(valid1), .o_frame_err(err1),
    .o_btn_plus_1(p1), .o_btn_plus_5(p5), .o_btn_minus_1(m1),
    .o_btn_minus_5(m5), .o_btn_reset(rs));

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .CMD_ENABLE(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx0),
    .o_rx_byte(byte0), .o_rx_valid(valid0), .o_frame_err(err0),
    .o_btn_plus_1(q1), .o_btn_plus_5(q5), .o_btn_minus_1(n1),
    .o_btn_minus_5(n5), .o_btn_reset(ns));

  int n_vec = 0, n_bad = 0;
  logic [7:0] q_b[$], q_b0[$];
  logic [4:0] q_c[$];
  int n_err = 0, n_err0 = 0, n_stray = 0, n_stray0 = 0;
  logic [7:0] exp_last = 8'h00;
  logic [7:0] cmd_chars [10] = '{8'h2B, 8'h75, 8'h55, 8'h2D, 8'h64,
                                 8'h44, 8'h72, 8'h52, 8'h78, 8'h41};

  // Reference: byte -> {reset, -5, -1, +5, +1}
  function automatic logic [4:0] cmd_of(input logic [7:0] b);
    case (b)
      8'h2B, 8'h75: return 5'b00001;
      8'h55:        return 5'b00010;
      8'h2D, 8'h64: return 5'b00100;
      8'h44:        return 5'b01000;
      8'h72, 8'h52: return 5'b10000;
      default:      return 5'b00000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid1) begin q_b.push_back(byte1); q_c.push_back(cmd1); end
      else if (cmd1 != 5'b0) n_stray++;
      if ($countones(cmd1) > 1) n_stray++;
      if (err1) n_err++;
      if (valid0) q_b0.push_back(byte0);
      if (cmd0 != 5'b0) n_stray0++;
      if (err0) n_err0++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    q_b.delete(); q_c.delete(); q_b0.delete();
    n_err = 0; n_err0 = 0; n_stray = 0; n_stray0 = 0;
  endtask

  // num = ten bit-times in cycles; non-multiples of 10 give jittered bit lengths
  task automatic send_byte(input bit ln, input logic [7:0] b, input bit stop, input int num);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      if (ln) rx0 = fr[j]; else rx = fr[j];
      wait_cyc(((j + 1) * num) / 10 - (j * num) / 10);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    wait_cyc(3);
    n_vec++;
    if ({byte1, valid1, err1, cmd1, byte0, valid0, err0, cmd0} !== 30'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b %h/%b/%b/%b want all zero",
               byte1, valid1, err1, cmd1, byte0, valid0, err0, cmd0);
    end
    rst_n = 1'b1;
    wait_cyc(2 * CPB);
    n_vec++;
    if ({valid1, err1, cmd1, valid0, err0, cmd0} !== 14'b0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL reset_idle: activity on idle line after reset, valids=%0d", q_b.size());
    end
  endtask

  task automatic test_nominal();
    logic [7:0] exp_b[$];
    logic [7:0] b;
    clr_mon();
    exp_b.push_back(8'h2B);
    for (int i = 0; i < 10; i++) begin
      b = $urandom_range(0, 1) ? cmd_chars[$urandom_range(0, 9)] : 8'($urandom_range(0, 255));
      exp_b.push_back(b);
    end
    foreach (exp_b[i]) begin
      send_byte(1'b0, exp_b[i], 1'b1, NOM);
      wait_cyc($urandom_range(0, 3 * CPB));
    end
    wait_cyc(3 * CPB);
    n_vec++;
    if (q_b.size() != exp_b.size()) begin
      n_bad++;
      $display("FAIL nominal_count: got %0d valids want %0d", q_b.size(), exp_b.size());
    end else begin
      foreach (exp_b[i]) begin
        n_vec++;
        if (q_b[i] !== exp_b[i] || q_c[i] !== cmd_of(exp_b[i])) begin
          n_bad++;
          $display("FAIL nominal_byte%0d: got %h cmd %b want %h cmd %b",
                   i, q_b[i], q_c[i], exp_b[i], cmd_of(exp_b[i]));
        end
      end
    end
    exp_last = exp_b[exp_b.size() - 1];
    n_vec++;
    if (byte1 !== exp_last || n_err != 0 || n_stray != 0) begin
      n_bad++;
      $display("FAIL nominal_misc: byte %h want %h, errs %0d stray %0d want 0/0",
               byte1, exp_last, n_err, n_stray);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[$];
    clr_mon();
    exp_b = '{8'h55, 8'h44, 8'h72, 8'h78};
    foreach (exp_b[i]) send_byte(1'b0, exp_b[i], 1'b1, NOM);
    wait_cyc(3 * CPB);
    n_vec++;
    if (q_b.size() != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d valids want 4", q_b.size());
    end else begin
      foreach (exp_b[i]) begin
        n_vec++;
        if (q_b[i] !== exp_b[i] || q_c[i] !== cmd_of(exp_b[i])) begin
          n_bad++;
          $display("FAIL b2b_byte%0d: got %h cmd %b want %h cmd %b",
                   i, q_b[i], q_c[i], exp_b[i], cmd_of(exp_b[i]));
        end
      end
    end
    exp_last = 8'h78;
    n_vec++;
    if (byte1 !== 8'h78 || n_err != 0 || n_stray != 0) begin
      n_bad++;
      $display("FAIL b2b_final: byte %h want 78, errs %0d stray %0d", byte1, n_err, n_stray);
    end
  endtask

  task automatic test_frame_err();
    clr_mon();
    send_byte(1'b0, 8'h55, 1'b0, NOM);
    wait_cyc(40 * CPB);
    rx = 1'b1;
    wait_cyc(2 * CPB);
    n_vec++;
    if (n_err != 1 || q_b.size() != 0 || n_stray != 0) begin
      n_bad++;
      $display("FAIL ferr_break: errs %0d valids %0d stray %0d want 1/0/0",
               n_err, q_b.size(), n_stray);
    end
    n_vec++;
    if (byte1 !== exp_last) begin
      n_bad++;
      $display("FAIL ferr_hold: byte %h want %h", byte1, exp_last);
    end
    send_byte(1'b0, 8'h2D, 1'b1, NOM);
    wait_cyc(3 * CPB);
    exp_last = 8'h2D;
    n_vec++;
    if (n_err != 1 || q_b.size() != 1 || (q_b.size() == 1 && (q_b[0] !== 8'h2D || q_c[0] !== 5'b00100))) begin
      n_bad++;
      $display("FAIL ferr_recover: errs %0d valids %0d byte %h want 1/1/2d minus_1", n_err,
               q_b.size(), byte1);
    end
  endtask

  task automatic test_glitch();
    clr_mon();
    rx = 1'b0;
    wait_cyc(5);
    rx = 1'b1;
    wait_cyc(3 * CPB);
    n_vec++;
    if (q_b.size() != 0 || n_err != 0 || n_stray != 0) begin
      n_bad++;
      $display("FAIL glitch_quiet: valids %0d errs %0d stray %0d want 0", q_b.size(), n_err, n_stray);
    end
    send_byte(1'b0, 8'h2B, 1'b1, NOM);
    wait_cyc(3 * CPB);
    exp_last = 8'h2B;
    n_vec++;
    if (q_b.size() != 1 || (q_b.size() == 1 && (q_b[0] !== 8'h2B || q_c[0] !== 5'b00001))) begin
      n_bad++;
      $display("FAIL glitch_next: valids %0d byte %h want 1 valid of 2b plus_1", q_b.size(), byte1);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] fr;
    clr_mon();
    fr = {1'b1, 8'h2B, 1'b0};
    for (int j = 0; j < 5; j++) begin rx = fr[j]; wait_cyc(CPB); end
    rx = fr[5];
    wait_cyc(CPB / 2);
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({byte1, valid1, err1, cmd1} !== 15'b0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h/%b/%b/%b want zero", byte1, valid1, err1, cmd1);
    end
    rx = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    exp_last = 8'h00;
    wait_cyc(12 * CPB);
    n_vec++;
    if (q_b.size() != 0 || n_err != 0 || n_stray != 0 || byte1 !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_quiet: valids %0d errs %0d stray %0d byte %h want 0", q_b.size(),
               n_err, n_stray, byte1);
    end
    send_byte(1'b0, 8'h64, 1'b1, NOM);
    wait_cyc(3 * CPB);
    exp_last = 8'h64;
    n_vec++;
    if (q_b.size() != 1 || (q_b.size() == 1 && (q_b[0] !== 8'h64 || q_c[0] !== 5'b00100))) begin
      n_bad++;
      $display("FAIL rstmid_next: valids %0d byte %h want 1 valid of 64 minus_1", q_b.size(), byte1);
    end
  endtask

  task automatic test_jitter();
    logic [7:0] exp_b[$];
    int rates [2] = '{154, 166};
    clr_mon();
    foreach (rates[r]) begin
      for (int i = 0; i < 6; i++) begin
        exp_b.push_back(i[0] ? cmd_chars[$urandom_range(0, 7)] : 8'($urandom_range(0, 255)));
        send_byte(1'b1, exp_b[exp_b.size() - 1], 1'b1, rates[r]);
      end
      wait_cyc(3 * CPB);
    end
    n_vec++;
    if (q_b0.size() != exp_b.size()) begin
      n_bad++;
      $display("FAIL jitter_count: got %0d valids want %0d", q_b0.size(), exp_b.size());
    end else begin
      foreach (exp_b[i]) begin
        n_vec++;
        if (q_b0[i] !== exp_b[i]) begin
          n_bad++;
          $display("FAIL jitter_byte%0d: got %h want %h", i, q_b0[i], exp_b[i]);
        end
      end
    end
    n_vec++;
    if (n_stray0 != 0 || n_err0 != 0) begin
      n_bad++;
      $display("FAIL jitter_nocmd: stray %0d errs %0d want 0/0", n_stray0, n_err0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_jitter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
